// File: rtl/awg_pkg.sv
// Shared encodings, field limits and reset values for the AWG front-panel controller.
package awg_pkg;

    typedef enum logic [1:0] {
        SEL_FREQ  = 2'd0,
        SEL_AMP   = 2'd1,
        SEL_PHASE = 2'd2
    } sel_mode_t;

    localparam logic [11:0] FREQ_MIN = 12'd1;
    localparam logic [11:0] FREQ_MAX = 12'd4095;
    localparam logic [2:0]  AMP_MIN  = 3'd1;
    localparam logic [2:0]  AMP_MAX  = 3'd7;

    localparam logic        RESET_EN    = 1'b0;
    localparam logic [11:0] RESET_FREQ  = FREQ_MIN;
    localparam logic [2:0]  RESET_AMP   = AMP_MIN;
    localparam logic [7:0]  RESET_PHASE = 8'd0;
    localparam sel_mode_t   RESET_SEL   = SEL_FREQ;

    function automatic sel_mode_t next_sel(input sel_mode_t cur);
        case (cur)
            SEL_FREQ: next_sel = SEL_AMP;
            SEL_AMP:  next_sel = SEL_PHASE;
            default:  next_sel = SEL_FREQ;
        endcase
    endfunction

endpackage

// File: rtl/awg_ctrl_key_debounce.sv
// One push button: 2-flop synchronizer, level debouncer and single-cycle press pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pressed,
    output logic level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level_d;
    logic [1:0]       warm;
    logic             seeded;
    logic             armed;
    logic [CNT_W-1:0] cnt;

    // A key found low once the synchronizer has flushed its reset value stays
    // unarmed until a debounced release, so holding it through reset is silent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
            warm    <= 2'b00;
            seeded  <= 1'b0;
            armed   <= 1'b0;
            cnt     <= '0;
            pressed <= 1'b0;
        end else begin
            sync1   <= key_n;
            sync2   <= sync1;
            warm    <= {warm[0], 1'b1};
            level_d <= level;
            pressed <= armed & level_d & ~level;

            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                    if (sync2) begin
                        armed <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end

            if (warm[1] && !seeded) begin
                seeded <= 1'b1;
                armed  <= sync2;
            end
        end
    end

endmodule

// File: rtl/awg_ctrl.sv
// Front-panel controller for the waveform generator: four debounced keys drive the field FSM.
// Optional AWG_CTRL_AUTOREPEAT_EN adds hold-to-repeat on the up/down keys.
module awg_ctrl
    import awg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FREQ_STEP       = 1,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_sel,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_en,
    output logic        en,
    output logic [11:0] state_freq,
    output logic [2:0]  state_amp,
    output logic [7:0]  state_phase,
    output logic [1:0]  sel_mode
);

    localparam logic [12:0] STEP_W = 13'(FREQ_STEP);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (FREQ_STEP < 1 || FREQ_STEP > 4094) begin : g_bad_step
        $error("FREQ_STEP must lie in 1..4094");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be at least 1");
    end

    logic sel_press, up_press, down_press, en_press;
    logic sel_level, up_level, down_level, en_level;
    logic up_ev, down_ev;
    logic unused_levels;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_sel (
        .clk(clk), .rst(rst), .key_n(key_sel), .pressed(sel_press), .level(sel_level)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
        .clk(clk), .rst(rst), .key_n(key_up), .pressed(up_press), .level(up_level)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_down (
        .clk(clk), .rst(rst), .key_n(key_down), .pressed(down_press), .level(down_level)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_en (
        .clk(clk), .rst(rst), .key_n(key_en), .pressed(en_press), .level(en_level)
    );

`ifdef AWG_CTRL_AUTOREPEAT_EN
    localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [1:0]            rpt_held;
    logic [1:0]            rpt_pulse;
    logic [1:0][RPT_W-1:0] rpt_cnt;
    logic [1:0]            rpt_level;
    logic [1:0]            rpt_press;

    assign rpt_level = {down_level, up_level};
    assign rpt_press = {down_press, up_press};

    // Repeats only follow a genuine press, so a key held through reset never repeats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_held  <= '0;
            rpt_pulse <= '0;
            rpt_cnt   <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rpt_pulse[i] <= 1'b0;
                if (rpt_level[i]) begin
                    rpt_held[i] <= 1'b0;
                    rpt_cnt[i]  <= '0;
                end else if (rpt_press[i]) begin
                    rpt_held[i] <= 1'b1;
                    rpt_cnt[i]  <= '0;
                end else if (rpt_held[i]) begin
                    if (rpt_cnt[i] == RPT_LAST) begin
                        rpt_cnt[i]   <= '0;
                        rpt_pulse[i] <= 1'b1;
                    end else begin
                        rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign up_ev         = up_press | rpt_pulse[0];
    assign down_ev       = down_press | rpt_pulse[1];
    assign unused_levels = sel_level & en_level;
`else
    assign up_ev         = up_press;
    assign down_ev       = down_press;
    assign unused_levels = sel_level & en_level & up_level & down_level;
`endif

    sel_mode_t   sel_state;
    logic [12:0] freq_sum;
    logic [12:0] freq_diff;
    logic [11:0] freq_inc;
    logic [11:0] freq_dec;
    logic [2:0]  amp_inc;
    logic [2:0]  amp_dec;

    // 13-bit arithmetic keeps the saturation compare free of wrap-around.
    always_comb begin
        freq_sum  = {1'b0, state_freq} + STEP_W;
        freq_diff = {1'b0, state_freq} - STEP_W;
        freq_inc  = (freq_sum > {1'b0, FREQ_MAX}) ? FREQ_MAX : freq_sum[11:0];
        freq_dec  = ({1'b0, state_freq} < ({1'b0, FREQ_MIN} + STEP_W)) ? FREQ_MIN : freq_diff[11:0];
        amp_inc   = (state_amp >= AMP_MAX) ? AMP_MAX : state_amp + 3'd1;
        amp_dec   = (state_amp <= AMP_MIN) ? AMP_MIN : state_amp - 3'd1;
    end

    // Adjustments use the selection held before this edge; sel advances alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en          <= RESET_EN;
            state_freq  <= RESET_FREQ;
            state_amp   <= RESET_AMP;
            state_phase <= RESET_PHASE;
            sel_state   <= RESET_SEL;
        end else begin
            if (en_press) begin
                en <= ~en;
            end
            if (up_ev ^ down_ev) begin
                case (sel_state)
                    SEL_FREQ:  state_freq  <= up_ev ? freq_inc : freq_dec;
                    SEL_AMP:   state_amp   <= up_ev ? amp_inc : amp_dec;
                    SEL_PHASE: state_phase <= up_ev ? state_phase + 8'd1 : state_phase - 8'd1;
                    default:   state_freq  <= state_freq;
                endcase
            end
            if (sel_press) begin
                sel_state <= next_sel(sel_state);
            end
        end
    end

    assign sel_mode = sel_state;

endmodule

// File: tb/tb_awg_ctrl.sv
// Randomized self-checking bench for awg_ctrl against a field-level behavioural model.
module tb_awg_ctrl;

    localparam int DEB    = 4;
    localparam int RPT    = 16;
    localparam int SETTLE = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_sel = 1'b1;
    logic        key_up = 1'b1;
    logic        key_down = 1'b1;
    logic        key_en = 1'b1;
    logic        en;
    logic [11:0] state_freq;
    logic [2:0]  state_amp;
    logic [7:0]  state_phase;
    logic [1:0]  sel_mode;

    int n_checks = 0;
    int n_fail   = 0;

    int m_en, m_freq, m_amp, m_phase, m_sel;

    always #5 clk = ~clk;

    awg_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .FREQ_STEP(1),
        .REPEAT_CYCLES(RPT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_sel(key_sel),
        .key_up(key_up),
        .key_down(key_down),
        .key_en(key_en),
        .en(en),
        .state_freq(state_freq),
        .state_amp(state_amp),
        .state_phase(state_phase),
        .sel_mode(sel_mode)
    );

    task automatic model_reset();
        m_en = 0; m_freq = 1; m_amp = 1; m_phase = 0; m_sel = 0;
    endtask

    task automatic model_event(input bit s, input bit u, input bit d, input bit e);
        if (e) m_en = 1 - m_en;
        if (u != d) begin
            case (m_sel)
                0: m_freq = u ? ((m_freq + 1 > 4095) ? 4095 : m_freq + 1)
                              : ((m_freq - 1 < 1) ? 1 : m_freq - 1);
                1: m_amp = u ? ((m_amp + 1 > 7) ? 7 : m_amp + 1)
                             : ((m_amp - 1 < 1) ? 1 : m_amp - 1);
                default: m_phase = u ? (m_phase + 1) % 256 : (m_phase + 255) % 256;
            endcase
        end
        if (s) m_sel = (m_sel + 1) % 3;
    endtask

    // mask bit 0 = sel, 1 = up, 2 = down, 3 = en
    task automatic drive_keys(input logic [3:0] mask, input logic val);
        if (mask[0]) key_sel = val;
        if (mask[1]) key_up = val;
        if (mask[2]) key_down = val;
        if (mask[3]) key_en = val;
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        @(negedge clk);
        drive_keys(mask, 1'b0);
        repeat (hold) @(negedge clk);
        drive_keys(mask, 1'b1);
        repeat (SETTLE) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_en: got %0b expected 0", en); end
        n_checks++; if (state_freq !== 12'd1) begin n_fail++; $display("[TB] FAIL reset_freq: got %0d expected 1", state_freq); end
        n_checks++; if (state_amp !== 3'd1) begin n_fail++; $display("[TB] FAIL reset_amp: got %0d expected 1", state_amp); end
        n_checks++; if (state_phase !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_phase: got %0d expected 0", state_phase); end
        n_checks++; if (sel_mode !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_sel: got %0d expected 0", sel_mode); end
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_latency();
        int cycles;
        for (int i = 0; i < 10; i++) begin
            model_event(0, 1, 0, 0);
            @(negedge clk);
            key_up = 1'b0;
            cycles = 0;
            while (state_freq !== 12'(m_freq) && cycles < 20) begin
                @(posedge clk); #1;
                cycles++;
            end
            n_checks++;
            if (cycles < DEB + 3 || cycles > DEB + 5) begin
                n_fail++; $display("[TB] FAIL latency press %0d: got %0d cycles expected %0d +/-1", i, cycles, DEB + 4);
            end
            @(negedge clk);
            key_up = 1'b1;
            repeat (SETTLE) @(negedge clk);
            n_checks++;
            if (state_freq !== 12'(m_freq)) begin
                n_fail++; $display("[TB] FAIL latency_freq: got %0d expected %0d", state_freq, m_freq);
            end
        end
        n_checks++;
        if (state_freq !== 12'd11) begin n_fail++; $display("[TB] FAIL freq_after_10: got %0d expected 11", state_freq); end
    endtask

    task automatic test_sel_phase();
        for (int i = 0; i < 3; i++) begin
            press(4'b0001, $urandom_range(DEB + 6, DEB + 10));
            model_event(1, 0, 0, 0);
            n_checks++;
            if (sel_mode !== 2'(m_sel)) begin n_fail++; $display("[TB] FAIL sel_cycle: got %0d expected %0d", sel_mode, m_sel); end
        end
        n_checks++;
        if (sel_mode !== 2'd0) begin n_fail++; $display("[TB] FAIL sel_wrap: got %0d expected 0", sel_mode); end
        repeat (2) begin
            press(4'b0001, DEB + 6);
            model_event(1, 0, 0, 0);
        end
        n_checks++;
        if (sel_mode !== 2'd2) begin n_fail++; $display("[TB] FAIL sel_phase: got %0d expected 2", sel_mode); end
        press(4'b0100, DEB + 6);
        model_event(0, 0, 1, 0);
        n_checks++;
        if (state_phase !== 8'd255) begin n_fail++; $display("[TB] FAIL phase_underflow: got %0d expected 255", state_phase); end
        press(4'b0010, DEB + 6);
        model_event(0, 1, 0, 0);
        n_checks++;
        if (state_phase !== 8'd0) begin n_fail++; $display("[TB] FAIL phase_overflow: got %0d expected 0", state_phase); end
        for (int i = 0; i < 300; i++) begin
            press(4'b0010, $urandom_range(DEB + 6, DEB + 10));
            model_event(0, 1, 0, 0);
            n_checks++;
            if (state_phase !== 8'(m_phase)) begin
                n_fail++; $display("[TB] FAIL phase_up %0d: got %0d expected %0d", i, state_phase, m_phase);
            end
        end
    endtask

    task automatic test_amp_saturation();
        repeat (2) begin
            press(4'b0001, DEB + 6);
            model_event(1, 0, 0, 0);
        end
        n_checks++;
        if (sel_mode !== 2'd1) begin n_fail++; $display("[TB] FAIL sel_amp: got %0d expected 1", sel_mode); end
        for (int i = 0; i < 20; i++) begin
            if (i < 10) begin
                press(4'b0010, $urandom_range(DEB + 6, DEB + 10));
                model_event(0, 1, 0, 0);
            end else begin
                press(4'b0100, $urandom_range(DEB + 6, DEB + 10));
                model_event(0, 0, 1, 0);
            end
            n_checks++;
            if (state_amp !== 3'(m_amp) || state_amp === 3'd0) begin
                n_fail++; $display("[TB] FAIL amp_step %0d: got %0d expected %0d", i, state_amp, m_amp);
            end
            if (i == 9) begin
                n_checks++;
                if (state_amp !== 3'd7) begin n_fail++; $display("[TB] FAIL amp_max: got %0d expected 7", state_amp); end
            end
        end
        n_checks++;
        if (state_amp !== 3'd1) begin n_fail++; $display("[TB] FAIL amp_min: got %0d expected 1", state_amp); end
    endtask

    task automatic test_bounce_and_concurrent();
        logic [3:0] mask;
        int len;
        for (int i = 0; i < 6; i++) begin
            mask = (i == 0) ? 4'b0010 : 4'b0001 << $urandom_range(0, 3);
            len  = (i == 0) ? 3 : $urandom_range(1, DEB - 1);
            press(mask, len);
            n_checks++;
            if (en !== 1'(m_en) || state_freq !== 12'(m_freq) || state_amp !== 3'(m_amp) ||
                state_phase !== 8'(m_phase) || sel_mode !== 2'(m_sel)) begin
                n_fail++;
                $display("[TB] FAIL bounce key=%b len=%0d: got en=%0d f=%0d a=%0d p=%0d s=%0d expected en=%0d f=%0d a=%0d p=%0d s=%0d",
                         mask, len, en, state_freq, state_amp, state_phase, sel_mode,
                         m_en, m_freq, m_amp, m_phase, m_sel);
            end
        end
        press(4'b0110, DEB + 6);
        model_event(0, 1, 1, 0);
        n_checks++;
        if (state_freq !== 12'(m_freq) || state_amp !== 3'(m_amp) || state_phase !== 8'(m_phase)) begin
            n_fail++; $display("[TB] FAIL up_down_same_cycle: got f=%0d a=%0d p=%0d expected f=%0d a=%0d p=%0d",
                               state_freq, state_amp, state_phase, m_freq, m_amp, m_phase);
        end
        press(4'b0011, DEB + 6);
        model_event(1, 1, 0, 0);
        n_checks++;
        if (sel_mode !== 2'(m_sel) || state_freq !== 12'(m_freq) || state_amp !== 3'(m_amp) ||
            state_phase !== 8'(m_phase)) begin
            n_fail++; $display("[TB] FAIL sel_with_up: got s=%0d f=%0d a=%0d p=%0d expected s=%0d f=%0d a=%0d p=%0d",
                               sel_mode, state_freq, state_amp, state_phase, m_sel, m_freq, m_amp, m_phase);
        end
    endtask

    task automatic test_enable();
        press(4'b1000, DEB + 6);
        model_event(0, 0, 0, 1);
        n_checks++;
        if (en !== 1'b1) begin n_fail++; $display("[TB] FAIL en_first: got %0b expected 1", en); end
        press(4'b1000, DEB + 6);
        model_event(0, 0, 0, 1);
        n_checks++;
        if (en !== 1'b0) begin n_fail++; $display("[TB] FAIL en_second: got %0b expected 0", en); end
    endtask

    task automatic test_reset_held();
        @(negedge clk);
        key_up = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (en !== 1'b0 || state_freq !== 12'd1 || state_amp !== 3'd1 || state_phase !== 8'd0 || sel_mode !== 2'd0) begin
            n_fail++; $display("[TB] FAIL reset_mid_debounce: got en=%0d f=%0d a=%0d p=%0d s=%0d expected 0/1/1/0/0",
                               en, state_freq, state_amp, state_phase, sel_mode);
        end
        rst = 1'b0;
        model_reset();
        repeat (30) @(negedge clk);
        n_checks++;
        if (state_freq !== 12'd1) begin n_fail++; $display("[TB] FAIL held_through_reset: got %0d expected 1", state_freq); end
        key_up = 1'b1;
        repeat (SETTLE) @(negedge clk);
        n_checks++;
        if (state_freq !== 12'd1) begin n_fail++; $display("[TB] FAIL release_after_reset: got %0d expected 1", state_freq); end
        press(4'b0010, DEB + 6);
        model_event(0, 1, 0, 0);
        n_checks++;
        if (state_freq !== 12'd2) begin n_fail++; $display("[TB] FAIL repress_after_reset: got %0d expected 2", state_freq); end
    endtask

    task automatic test_random();
        logic [3:0] mask;
        int kind;
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                mask = 4'b0001 << $urandom_range(0, 3);
                press(mask, $urandom_range(DEB + 6, DEB + 10));
                model_event(mask[0], mask[1], mask[2], mask[3]);
            end else if (kind <= 7) begin
                mask = (4'b0001 << $urandom_range(0, 3)) | (4'b0001 << $urandom_range(0, 3));
                press(mask, $urandom_range(DEB + 6, DEB + 10));
                model_event(mask[0], mask[1], mask[2], mask[3]);
            end else begin
                mask = 4'b0001 << $urandom_range(0, 3);
                press(mask, $urandom_range(1, DEB - 1));
            end
            n_checks++;
            if (en !== 1'(m_en) || state_freq !== 12'(m_freq) || state_amp !== 3'(m_amp) ||
                state_phase !== 8'(m_phase) || sel_mode !== 2'(m_sel)) begin
                n_fail++;
                $display("[TB] FAIL random %0d key=%b: got en=%0d f=%0d a=%0d p=%0d s=%0d expected en=%0d f=%0d a=%0d p=%0d s=%0d",
                         i, mask, en, state_freq, state_amp, state_phase, sel_mode,
                         m_en, m_freq, m_amp, m_phase, m_sel);
            end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        @(negedge clk);
        key_up = 1'b0;
        repeat (100) @(negedge clk);
        key_up = 1'b1;
        repeat (SETTLE) @(negedge clk);
`ifdef AWG_CTRL_AUTOREPEAT_EN
        n_checks++;
        if (state_freq < 12'd6 || state_freq > 12'd8) begin
            n_fail++; $display("[TB] FAIL autorepeat: got %0d expected 7 +/-1", state_freq);
        end
`else
        model_event(0, 1, 0, 0);
        n_checks++;
        if (state_freq !== 12'(m_freq)) begin
            n_fail++; $display("[TB] FAIL single_event_hold: got %0d expected %0d", state_freq, m_freq);
        end
`endif
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_sel_phase();
        test_amp_saturation();
        test_bounce_and_concurrent();
        test_enable();
        test_reset_held();
        test_random();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/awg_ctrl.md
AWG_CTRL -- requirements
Module: awg_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1000000, cycles a raw key must hold a new level before it is accepted.
REQ-002 Parameter: FREQ_STEP, default 1, state_freq increment/decrement per press.
REQ-003 Parameter: REPEAT_CYCLES, default 10000000, auto-repeat period; used only under the configuration macro.
REQ-004 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: key_sel  input  1  raw push button, active-low, asynchronous to clk; cycles the selected field.
REQ-007 Port: key_up  input  1  raw push button, active-low; increments the selected field.
REQ-008 Port: key_down  input  1  raw push button, active-low; decrements the selected field.
REQ-009 Port: key_en  input  1  raw push button, active-low; toggles en.
REQ-010 Port: en  output  1  generator output enable, registered.
REQ-011 Port: state_freq  output  12  phase-accumulator increment, registered.
REQ-012 Port: state_amp  output  3  amplitude divisor, registered, never 0.
REQ-013 Port: state_phase  output  8  phase offset, registered.
REQ-014 Port: sel_mode  output  2  current selection, registered: 0=FREQ, 1=AMP, 2=PHASE.

Function
REQ-015 Each key SHALL pass through a 2-flop synchronizer, then a debounce counter that accepts a new level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-016 A press event SHALL be a single-cycle pulse on the accepted high-to-low transition; release generates no event.
REQ-017 The FSM SHALL have states SEL_FREQ, SEL_AMP, SEL_PHASE and advance FREQ->AMP->PHASE->FREQ on each sel event.
REQ-018 An up/down event SHALL modify only the field selected in the cycle the event is seen, with the new value visible on the next clock edge.
REQ-019 state_freq SHALL saturate within 1..4095: up adds FREQ_STEP, clamped to 4095; down subtracts FREQ_STEP, clamped to 1; arithmetic is at least 13 bits wide, so no wrap occurs.
REQ-020 state_amp SHALL saturate within 1..7; the value 0 is unreachable.
REQ-021 state_phase SHALL wrap modulo 256 in both directions: 255+1=0 and 0-1=255.
REQ-022 If up and down events occur in the same cycle, both SHALL be ignored.
REQ-023 If sel and up/down events occur in the same cycle, the adjustment SHALL apply to the old selection and sel_mode SHALL advance on the same edge.
REQ-024 An en event SHALL toggle en, independent of sel_mode and concurrent events.
REQ-025 Latency from a raw key settling low to the output change SHALL be DEBOUNCE_CYCLES+4 cycles, with a tolerance of +/-1.
REQ-026 Bounces shorter than DEBOUNCE_CYCLES SHALL produce no event.

Reset
REQ-027 On rst, asynchronously: en=0, state_freq=1, state_amp=1, state_phase=0, sel_mode=0 (SEL_FREQ).
REQ-028 On rst, asynchronously: synchronizers and debounced levels set to 1 (released), and all counters cleared.
REQ-029 A key held low through reset deassertion SHALL generate a press event only after it is released and pressed again.

Configuration
REQ-030 Macro AWG_CTRL_AUTOREPEAT_EN, when defined: holding up or down after the initial event SHALL generate a further event every REPEAT_CYCLES until release; sel and en never repeat.
REQ-031 Without AWG_CTRL_AUTOREPEAT_EN: exactly one event per press, the repeat counter is not present, and REPEAT_CYCLES is unused.

Structure
REQ-032 Package awg_pkg SHALL hold the sel_mode encoding, FREQ_MIN/FREQ_MAX (1/4095), AMP_MIN/AMP_MAX (1/7), and the reset values.
REQ-033 Sub-module key_debounce (synchronizer, debounce counter, press pulse; clk, rst, key_n in; pressed, level out) SHALL be instantiated once per key.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16 for simulation)
REQ-034 Reset, then 10 clean up presses in SEL_FREQ -> state_freq=11, and each change occurs 8+/-1 cycles after the key settles.
REQ-035 3 sel presses, then 300 up presses in SEL_PHASE -> sel_mode returns to 0; second pass in SEL_PHASE: 0-1 -> state_phase=255, 255+1 -> 0.
REQ-036 SEL_AMP: 10 up presses -> state_amp=7; then 10 down presses -> state_amp=1, never 0.
REQ-037 A bounce pulse of 3 cycles low on key_up -> no change; up and down pressed in the same cycle -> no change.
REQ-038 key_en pressed twice -> en 0->1->0; rst asserted mid-debounce with key held -> all outputs at reset values, no event until release and re-press.
REQ-039 With AWG_CTRL_AUTOREPEAT_EN defined, key_up held 100 cycles in SEL_FREQ -> state_freq=1+1+floor((100-8)/16)=7, within +/-1.
